memory_bus_responder: RTL and testbench

// Memory-side endpoint of the MemoryBus request/response mailbox protocol.

---
 rtl/memory_bus_responder.sv | 135 +++++++++++++
 tb/tb_memory_bus_responder.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/memory_bus_responder.sv
`default_nettype none
// ============================================================================
//  Module      : memory_bus_responder
//  Description : Memory-side MemoryBus endpoint that services one read/write
//                request at a time against an internal word store.
//  Revision    : 1.0  initial release
// ============================================================================
module memory_bus_responder #(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int SRC_W          = 4,
    parameter int DEPTH          = 256,
    parameter int WORD_LSB       = 2,
    parameter int ACCESS_LATENCY = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              request_busy,
    input  logic [1:0]        request_type,
    input  logic [SRC_W-1:0]  request_source,
    input  logic [ADDR_W-1:0] request_address,
    input  logic [DATA_W-1:0] request_payload,
    output logic              request_accept,
    input  logic              response_busy,
    output logic              response_send,
    output logic [1:0]        response_type,
    output logic [SRC_W-1:0]  response_source,
    output logic [ADDR_W-1:0] response_address,
    output logic [DATA_W-1:0] response_payload,
    output logic              idle,
    output logic              bad_request
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = (ACCESS_LATENCY > 1) ? $clog2(ACCESS_LATENCY) : 1;
    localparam logic [1:0] TYPE_WRITE    = 2'd1;
    localparam logic [1:0] TYPE_RESPONSE = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ACCESS  = 2'd1,
        S_RESPOND = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [1:0]         type_q;
    logic [SRC_W-1:0]   src_q;
    logic [IDX_W-1:0]   idx_q;
    logic [DATA_W-1:0]  wdata_q;
    logic [DATA_W-1:0]  rdata_q;
    logic               bad_q;
    logic [DATA_W-1:0]  mem_q [DEPTH];
    logic               access_done;
    logic               addr_unused;

    // Only the word-index bits select a location; the rest wrap silently.
    assign addr_unused = ^request_address;
    assign access_done = (state_q == S_ACCESS) && (cnt_q == '0);

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        request_accept = 1'b0;
        response_send  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (request_busy) begin
                    request_accept = 1'b1;
                    if (!request_type[1]) begin
                        state_d = S_ACCESS;
                        cnt_d   = CNT_W'(ACCESS_LATENCY - 1);
                    end
                end
            end
            S_ACCESS: begin
                if (cnt_q == '0) begin
                    state_d = (type_q == TYPE_WRITE) ? S_IDLE : S_RESPOND;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_RESPOND: begin
                if (!response_busy) begin
                    response_send = 1'b1;
                    state_d       = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            type_q  <= '0;
            src_q   <= '0;
            idx_q   <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            bad_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bad_q   <= request_accept && request_type[1];
            if (request_accept) begin
                type_q  <= request_type;
                src_q   <= request_source;
                idx_q   <= request_address[WORD_LSB +: IDX_W];
                wdata_q <= request_payload;
            end
            if (access_done && (type_q != TYPE_WRITE)) begin
                rdata_q <= mem_q[idx_q];
            end
        end
    end

    // Store is intentionally not reset; an aborted access never reaches here
    // because reset forces state_q out of ACCESS.
    always_ff @(posedge clk) begin
        if (access_done && (type_q == TYPE_WRITE)) begin
            mem_q[idx_q] <= wdata_q;
        end
    end

    assign response_type    = response_send ? TYPE_RESPONSE : 2'd0;
    assign response_source  = src_q;
    assign response_address = '0;
    assign response_payload = rdata_q;
    assign idle             = (state_q == S_IDLE);
    assign bad_request      = bad_q;

endmodule
`default_nettype wire

// File: tb/tb_memory_bus_responder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_memory_bus_responder
//  Description : Directed self-checking bench for memory_bus_responder.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_memory_bus_responder;

    logic        clk = 1'b0;
    logic        reset;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Main instance, ACCESS_LATENCY = 2
    logic        request_busy, request_accept, response_busy, response_send;
    logic [1:0]  request_type, response_type;
    logic [3:0]  request_source, response_source;
    logic [31:0] request_address, request_payload, response_address, response_payload;
    logic        idle, bad_request;

    memory_bus_responder #(.ACCESS_LATENCY(2)) dut (
        .clk(clk), .reset(reset),
        .request_busy(request_busy), .request_type(request_type),
        .request_source(request_source), .request_address(request_address),
        .request_payload(request_payload), .request_accept(request_accept),
        .response_busy(response_busy), .response_send(response_send),
        .response_type(response_type), .response_source(response_source),
        .response_address(response_address), .response_payload(response_payload),
        .idle(idle), .bad_request(bad_request)
    );

    // Second instance, ACCESS_LATENCY = 1, for the streaming case
    logic        rb1, acc1, send1, idle1, bad1;
    logic [1:0]  rt1, rtype1;
    logic [3:0]  rs1, rsrc1;
    logic [31:0] ra1, rp1, raddr1, rpay1;

    memory_bus_responder #(.ACCESS_LATENCY(1)) dut1 (
        .clk(clk), .reset(reset),
        .request_busy(rb1), .request_type(rt1),
        .request_source(rs1), .request_address(ra1),
        .request_payload(rp1), .request_accept(acc1),
        .response_busy(1'b0), .response_send(send1),
        .response_type(rtype1), .response_source(rsrc1),
        .response_address(raddr1), .response_payload(rpay1),
        .idle(idle1), .bad_request(bad1)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic req(input logic [1:0] t, input logic [3:0] s,
                       input logic [31:0] a, input logic [31:0] d);
        int n;
        request_busy    = 1'b1;
        request_type    = t;
        request_source  = s;
        request_address = a;
        request_payload = d;
        #1;
        n = 0;
        while (!request_accept && n < 40) begin
            tick();
            n++;
        end
        check("accept", {31'd0, request_accept}, 32'd1);
        tick();
        request_busy = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (!idle && n < 40) begin
            tick();
            n++;
        end
        check("idle_wait", {31'd0, idle}, 32'd1);
    endtask

    task automatic wr(input logic [3:0] s, input logic [31:0] a, input logic [31:0] d);
        req(2'd1, s, a, d);
        wait_idle();
    endtask

    task automatic rd(input string tag, input logic [3:0] s, input logic [31:0] a,
                      input logic [31:0] exp);
        int n;
        req(2'd0, s, a, 32'd0);
        n = 1;
        while (!response_send && n < 40) begin
            tick();
            n++;
        end
        check({tag, "_lat"},  n, 32'd3);
        check({tag, "_data"}, response_payload, exp);
        check({tag, "_src"},  {28'd0, response_source}, {28'd0, s});
        check({tag, "_type"}, {30'd0, response_type}, 32'd2);
        check({tag, "_addr"}, response_address, 32'd0);
        tick();
        check({tag, "_idle"}, {31'd0, idle}, 32'd1);
    endtask

    task automatic rd1(input string tag, input logic [31:0] a, input logic [31:0] exp);
        int n;
        rb1 = 1'b1; rt1 = 2'd0; rs1 = 4'd6; ra1 = a; rp1 = 32'd0;
        #1;
        n = 0;
        while (!acc1 && n < 40) begin
            tick();
            n++;
        end
        tick();
        rb1 = 1'b0;
        n = 1;
        while (!send1 && n < 40) begin
            tick();
            n++;
        end
        check({tag, "_lat"},  n, 32'd2);
        check({tag, "_data"}, rpay1, exp);
        tick();
    endtask

    int acc_cyc [4];

    initial begin
        reset = 1'b1;
        request_busy = 0; request_type = 0; request_source = 0;
        request_address = 0; request_payload = 0; response_busy = 0;
        rb1 = 0; rt1 = 0; rs1 = 0; ra1 = 0; rp1 = 0;
        tick();
        tick();
        check("rst_idle",  {31'd0, idle}, 32'd1);
        check("rst_send",  {31'd0, response_send}, 32'd0);
        check("rst_bad",   {31'd0, bad_request}, 32'd0);
        check("rst_type",  {30'd0, response_type}, 32'd0);
        check("rst_pay",   response_payload, 32'd0);
        check("rst_src",   {28'd0, response_source}, 32'd0);
        reset = 1'b0;
        tick();

        // Write then read the same word
        wr(4'd3, 32'h0000_0040, 32'hDEAD_BEEF);
        rd("rd40", 4'd5, 32'h0000_0040, 32'hDEAD_BEEF);

        // Reset mid-ACCESS aborts a pending write
        wr(4'd1, 32'h10, 32'h0000_1111);
        req(2'd1, 4'd1, 32'h10, 32'h0000_2222);
        reset = 1'b1;
        #1;
        check("midrst_idle", {31'd0, idle}, 32'd1);
        check("midrst_acc",  {31'd0, request_accept}, 32'd0);
        check("midrst_send", {31'd0, response_send}, 32'd0);
        check("midrst_bad",  {31'd0, bad_request}, 32'd0);
        tick();
        reset = 1'b0;
        tick();
        rd("rd10", 4'd2, 32'h10, 32'h0000_1111);

        // Response slot busy: hold, no new accept
        wr(4'd0, 32'h80, 32'hCAFE_F00D);
        response_busy = 1'b1;
        req(2'd0, 4'd7, 32'h80, 32'd0);
        tick();
        tick();
        request_busy = 1'b1; request_type = 2'd0; request_address = 32'h40;
        #1;
        for (int i = 0; i < 6; i++) begin
            check("hold_send", {31'd0, response_send}, 32'd0);
            check("hold_acc",  {31'd0, request_accept}, 32'd0);
            check("hold_pay",  response_payload, 32'hCAFE_F00D);
            check("hold_src",  {28'd0, response_source}, 32'd7);
            tick();
        end
        request_busy  = 1'b0;
        response_busy = 1'b0;
        #1;
        check("hold_release", {31'd0, response_send}, 32'd1);
        check("hold_rel_pay", response_payload, 32'hCAFE_F00D);
        tick();
        check("hold_idle", {31'd0, idle}, 32'd1);

        // Bad request type
        req(2'd2, 4'd9, 32'h40, 32'h5555_5555);
        check("bad_pulse", {31'd0, bad_request}, 32'd1);
        check("bad_idle",  {31'd0, idle}, 32'd1);
        check("bad_send",  {31'd0, response_send}, 32'd0);
        tick();
        check("bad_clear", {31'd0, bad_request}, 32'd0);
        check("bad_idle2", {31'd0, idle}, 32'd1);
        check("bad_send2", {31'd0, response_send}, 32'd0);
        rd("rd40b", 4'd4, 32'h40, 32'hDEAD_BEEF);

        // Address wrap modulo DEPTH words
        wr(4'd2, 32'h0000_0400, 32'h0000_1234);
        rd("wrap", 4'd8, 32'h0, 32'h0000_1234);

        // Continuous stream of writes on the single-cycle-access instance
        rb1 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            int n;
            rt1 = 2'd1; rs1 = 4'(i); ra1 = 32'(i * 4); rp1 = 32'hA0 + 32'(i);
            #1;
            n = 0;
            while (!acc1 && n < 20) begin
                tick();
                n++;
            end
            check("stream_acc", {31'd0, acc1}, 32'd1);
            acc_cyc[i] = cyc;
            if (i > 0) check("stream_gap", 32'(acc_cyc[i] - acc_cyc[i-1]), 32'd2);
            tick();
        end
        rb1 = 1'b0;
        tick();
        rd1("s0", 32'h0, 32'hA0);
        rd1("s1", 32'h4, 32'hA1);
        rd1("s2", 32'h8, 32'hA2);
        rd1("s3", 32'hC, 32'hA3);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
